sevseg_to_bcd: RTL

SEVSEG_TO_BCD -- requirements
Module: sevseg_to_bcd

---
 rtl/sevseg_to_bcd.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sevseg_to_bcd.sv
// sevseg_to_bcd: watches a multiplexed seven-segment display bus, waits for
// each digit to settle, decodes it, and publishes a complete frame of BCD
// nibbles once every digit position has been captured.
module sevseg_to_bcd #(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned STABLE_CYCLES = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg,
   input  logic [NUM_DIGITS-1:0]   dig_en,
   input  logic                    anode,
   output logic [4*NUM_DIGITS-1:0] bcd,
   output logic                    frame_valid,
   output logic                    frame_err
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned SMP_W = NUM_DIGITS + 7;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HOLD
   } state_t;

   state_t                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [SMP_W-1:0]        ref_q;
   logic [NUM_DIGITS-1:0]   seen_q;
   logic [NUM_DIGITS-1:0]   err_q;
   logic [4*NUM_DIGITS-1:0] stage_q;

   logic [6:0]       lit_c;
   logic [SMP_W-1:0] smp_c;
   logic             onehot_c;
   logic             same_c;
   logic             all_seen_c;
   logic [3:0]       nib_c;
   logic             bad_c;
   logic [CNT_W-1:0] cnt_d;
   logic             capture_c;

   // Normalise polarity so both display types compare and decode identically
   always_comb begin
      lit_c      = anode ? ~seg : seg;
      smp_c      = {dig_en, lit_c};
      onehot_c   = (dig_en != '0) && ((dig_en & (dig_en - NUM_DIGITS'(1))) == '0);
      same_c     = (smp_c == ref_q);
      all_seen_c = &seen_q;
   end

   // Segment pattern to nibble; blank is a legal digit, anything unknown flags an error
   always_comb begin
      nib_c = 4'hF;
      bad_c = 1'b1;
      case (lit_c)
         7'b1111110: begin nib_c = 4'h0; bad_c = 1'b0; end
         7'b0110000: begin nib_c = 4'h1; bad_c = 1'b0; end
         7'b1101101: begin nib_c = 4'h2; bad_c = 1'b0; end
         7'b1111001: begin nib_c = 4'h3; bad_c = 1'b0; end
         7'b0110011: begin nib_c = 4'h4; bad_c = 1'b0; end
         7'b1011011: begin nib_c = 4'h5; bad_c = 1'b0; end
         7'b1011111: begin nib_c = 4'h6; bad_c = 1'b0; end
         7'b1110000: begin nib_c = 4'h7; bad_c = 1'b0; end
         7'b1111111: begin nib_c = 4'h8; bad_c = 1'b0; end
         7'b1111011: begin nib_c = 4'h9; bad_c = 1'b0; end
         7'b0000000: begin nib_c = 4'hE; bad_c = 1'b0; end
         default:    begin nib_c = 4'hF; bad_c = 1'b1; end
      endcase
   end

   // Stability counter update and capture decision; HOLD with an unchanged
   // sample never recaptures, so a long-held digit is taken exactly once
   always_comb begin
      cnt_d = cnt_q;
      case (state_q)
         IDLE:    cnt_d = CNT_W'(1);
         SETTLE:  cnt_d = same_c ? cnt_q + CNT_W'(1) : CNT_W'(1);
         HOLD:    cnt_d = same_c ? cnt_q : CNT_W'(1);
         default: cnt_d = CNT_W'(1);
      endcase
      capture_c = onehot_c && !((state_q == HOLD) && same_c) &&
                  (cnt_d >= CNT_W'(STABLE_CYCLES));
   end

   // Settle FSM, staging slots and frame publication
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         ref_q       <= '0;
         seen_q      <= '0;
         err_q       <= '0;
         stage_q     <= {NUM_DIGITS{4'hF}};
         bcd         <= {NUM_DIGITS{4'hF}};
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_valid <= 1'b0;

         // Publish the frame one edge after the last slot fills; clearing
         // first lets a same-cycle capture land in the new frame
         if (all_seen_c) begin
            bcd         <= stage_q;
            frame_err   <= |err_q;
            frame_valid <= 1'b1;
            seen_q      <= '0;
            err_q       <= '0;
         end

         if (!onehot_c) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else begin
            ref_q <= smp_c;
            cnt_q <= cnt_d;
            case (state_q)
               IDLE, SETTLE: state_q <= capture_c ? HOLD : SETTLE;
               HOLD:         state_q <= same_c ? HOLD : (capture_c ? HOLD : SETTLE);
               default:      state_q <= IDLE;
            endcase
         end

         if (capture_c) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
               if (dig_en[i]) begin
                  stage_q[4*i +: 4] <= nib_c;
                  err_q[i]          <= bad_c;
                  seen_q[i]         <= 1'b1;
               end
            end
         end
      end
   end

endmodule
